// File: rtl/inst_data_sram_ctrl.sv
// Single-port SRAM controller arbitrating instruction-refill and data ports.
// Fixed wait-state access; all SRAM pins registered; one-cycle valid pulse per access.
module inst_data_sram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_valid,
    output logic              inst_stop,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_valid,
    output logic              data_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic last_data_q, last_data_d;   // 1: previous grant went to the data port
    logic gnt_data_q, gnt_data_d;
    logic we_q, we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [31:0] sram_wdata_q, sram_wdata_d;
    logic wdata_oe_q, wdata_oe_d;
    logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [3:0] be_n_q, be_n_d;
    logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic inst_valid_q, inst_valid_d, data_valid_q, data_valid_d;

    logic grant, pick_data, sel_we;

    // Data wins ties unless it also won the previous grant.
    assign pick_data = data_req & (~inst_req | ~last_data_q);
    assign grant     = (state_q == S_IDLE) & (inst_req | data_req);
    assign sel_we    = pick_data & data_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_data_q  <= 1'b0;
            gnt_data_q   <= 1'b0;
            we_q         <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            wdata_oe_q   <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            be_n_q       <= 4'hF;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_data_q  <= last_data_d;
            gnt_data_q   <= gnt_data_d;
            we_q         <= we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            wdata_oe_q   <= wdata_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            be_n_q       <= be_n_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == '0) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_data_d  = last_data_q;
        gnt_data_d   = gnt_data_q;
        we_d         = we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        wdata_oe_d   = wdata_oe_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        be_n_d       = be_n_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Strobes are loaded at grant so they are live from the first ACCESS cycle.
                if (grant) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    we_d        = sel_we;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    sram_addr_d = pick_data ? data_addr[ADDR_W+1:2] : inst_addr[ADDR_W+1:2];
                    if (pick_data) sram_wdata_d = data_wdata;
                    ce_n_d      = 1'b0;
                    oe_n_d      = sel_we;
                    we_n_d      = ~sel_we;
                    wdata_oe_d  = sel_we;
                    be_n_d      = pick_data ? ~data_be : 4'h0;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    we_n_d     = 1'b1;
                    wdata_oe_d = 1'b0;
                    be_n_d     = 4'hF;
                    if (gnt_data_q) begin
                        data_valid_d = 1'b1;
                        if (!we_q) data_rdata_d = sram_rdata;
                    end else begin
                        inst_valid_d = 1'b1;
                        if (!we_q) inst_rdata_d = sram_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign inst_rdata    = inst_rdata_q;
    assign inst_valid    = inst_valid_q;
    assign inst_stop     = inst_req & ~inst_valid_q;
    assign data_rdata    = data_rdata_q;
    assign data_valid    = data_valid_q;
    assign data_stall    = data_req & ~data_valid_q;
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;
    assign sram_wdata_oe = wdata_oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;

    // Byte-offset and above-window address bits never reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                                data_addr[31:ADDR_W+2], data_addr[1:0]};
endmodule

// File: tb/tb_inst_data_sram_ctrl.sv
// Bench for inst_data_sram_ctrl: table of single transactions plus arbitration,
// fairness and reset-abort sequences; responses checked from a scoreboard queue.
module tb_inst_data_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_valid, inst_stop;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_we, data_valid, data_stall;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic        sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    always #5 clk = ~clk;

    inst_data_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_valid(inst_valid), .inst_stop(inst_stop),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_valid(data_valid), .data_stall(data_stall),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    // SRAM stand-in: read word is a fixed function of the word address.
    function automatic logic [31:0] mem_f(input logic [19:0] a);
        return {a[11:0], a} ^ 32'h1357_0000;
    endfunction

    logic        use_fix = 1'b0;
    logic [31:0] fix_rd  = '0;
    assign sram_rdata = use_fix ? fix_rd : mem_f(sram_addr);

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } exp_t;

    typedef struct {
        bit          isd;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
    } vec_t;

    exp_t        qd[$], qi[$];
    exp_t        md, mi;
    vec_t        tbl[6];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [31:0] last_drd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor: every valid pulse must match the head of its port's queue.
    initial forever begin
        @(negedge clk);
        if (data_valid === 1'b1) begin
            if (qd.size() == 0) chk("unexpected data_valid", {31'b0, data_valid}, 32'd0);
            else begin
                md = qd.pop_front();
                chk("data_rdata", data_rdata, md.rdata);
                chk("data_valid cycle", 32'(cyc), 32'(md.due));
            end
        end
        if (inst_valid === 1'b1) begin
            if (qi.size() == 0) chk("unexpected inst_valid", {31'b0, inst_valid}, 32'd0);
            else begin
                mi = qi.pop_front();
                chk("inst_rdata", inst_rdata, mi.rdata);
                chk("inst_valid cycle", 32'(cyc), 32'(mi.due));
            end
        end
    end

    // Run until both queues drain; each port drops its request once its last response arrives.
    task automatic drain(input int budget);
        int  k = 0;
        bit  dv, iv;
        while ((qd.size() != 0 || qi.size() != 0) && k < budget) begin
            @(negedge clk);
            dv = data_valid;
            iv = inst_valid;
            @(posedge clk); #1;
            if (dv && qd.size() == 0) data_req = 1'b0;
            if (iv && qi.size() == 0) inst_req = 1'b0;
            k++;
        end
        chk("drain timeout", 32'(qd.size() + qi.size()), 32'd0);
        data_req = 1'b0;
        inst_req = 1'b0;
    endtask

    task automatic start(input bit isd, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (isd) begin
            data_we = we; data_be = be; data_addr = addr; data_wdata = wd; data_req = 1'b1;
        end else begin
            inst_addr = addr; inst_req = 1'b1;
        end
    endtask

    task automatic push(input bit isd, input bit we, input logic [19:0] a, input int due);
        exp_t e;
        e.due = due;
        if (isd) begin
            if (!we) last_drd = mem_f(a);
            e.rdata = last_drd;
            qd.push_back(e);
        end else begin
            e.rdata = mem_f(a);
            qi.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        tbl[0] = '{1'b1, 1'b1, 4'b0010, 32'h8000_0100, 32'h0000_AB00, 20'h00040, 4'b1101};
        tbl[1] = '{1'b1, 1'b0, 4'b1111, 32'h8000_0100, 32'h0,         20'h00040, 4'b0000};
        tbl[2] = '{1'b1, 1'b1, 4'b1111, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 20'hFFFFF, 4'b0000};
        tbl[3] = '{1'b1, 1'b0, 4'b0001, 32'h0000_0004, 32'h0,         20'h00001, 4'b1110};
        tbl[4] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0FFC, 32'h0,         20'h003FF, 4'b0000};
        tbl[5] = '{1'b0, 1'b0, 4'b0000, 32'h0040_0000, 32'h0,         20'h00000, 4'b0000};

        rst = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ce/oe/we/wdata_oe", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 32'hE);
        chk("reset be_n", {28'b0, sram_be_n}, 32'hF);
        chk("reset valid/stop/stall", {28'b0, inst_valid, data_valid, inst_stop, data_stall}, 32'h0);
        chk("reset sram_addr", {12'b0, sram_addr}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Lone instruction fetch with a fixed SRAM word
        use_fix = 1'b1; fix_rd = 32'h2408_0001;
        start(1'b0, 1'b0, 4'h0, 32'h8000_0010, 32'h0);
        begin exp_t e; e.rdata = 32'h2408_0001; e.due = cyc + 3; qi.push_back(e); end
        @(negedge clk);
        chk("T0 inst_stop", {31'b0, inst_stop}, 32'd1);
        chk("T0 ce_n idle", {31'b0, sram_ce_n}, 32'd1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("fetch sram_addr", {12'b0, sram_addr}, 32'h0000_0004);
            chk("fetch ce_n/oe_n/we_n", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h1);
            chk("fetch inst_stop", {31'b0, inst_stop}, 32'd1);
        end
        @(negedge clk);
        chk("T3 inst_valid/stop", {30'b0, inst_valid, inst_stop}, 32'h2);
        chk("T3 strobes released", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(negedge clk);
        chk("T4 inst_valid", {31'b0, inst_valid}, 32'd0);
        use_fix = 1'b0;
        @(posedge clk); #1;

        // Table of lone transactions; request inputs are scrambled mid-access
        for (int i = 0; i < 6; i++) begin
            start(tbl[i].isd, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd);
            push(tbl[i].isd, tbl[i].we, tbl[i].exp_addr, cyc + 3);
            @(negedge clk);
            chk("T0 ce_n", {31'b0, sram_ce_n}, 32'd1);
            for (int k = 1; k <= 2; k++) begin
                @(negedge clk);
                chk("acc sram_addr", {12'b0, sram_addr}, {12'b0, tbl[i].exp_addr});
                chk("acc be_n", {28'b0, sram_be_n}, {28'b0, tbl[i].exp_be_n});
                chk("acc ce/oe/we/oe_drv", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe},
                    {28'b0, 1'b0, tbl[i].we, !tbl[i].we, tbl[i].we});
                if (tbl[i].we) chk("acc sram_wdata", sram_wdata, tbl[i].wd);
                if (k == 1) begin
                    data_addr = ~data_addr; inst_addr = ~inst_addr;
                    data_be = ~data_be; data_wdata = ~data_wdata; data_we = ~data_we;
                end
            end
            drain(10);
        end

        // Simultaneous requests: data first (last grant was inst)
        start(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        start(1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        push(1'b1, 1'b0, 20'h00080, cyc + 3);
        push(1'b0, 1'b0, 20'h000C0, cyc + 7);
        drain(20);

        // Continuous dual requests for four transactions: D,I,D,I
        start(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
        start(1'b0, 1'b0, 4'h0, 32'h0000_0500, 32'h0);
        push(1'b1, 1'b0, 20'h00100, cyc + 3);
        push(1'b0, 1'b0, 20'h00140, cyc + 7);
        push(1'b1, 1'b0, 20'h00100, cyc + 11);
        push(1'b0, 1'b0, 20'h00140, cyc + 15);
        drain(30);

        // Reset during a read: no response, everything back to reset values
        start(1'b1, 1'b0, 4'hF, 32'h8000_0800, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        chk("abort strobes", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 32'hE);
        chk("abort be_n", {28'b0, sram_be_n}, 32'hF);
        chk("abort sram_addr", {12'b0, sram_addr}, 32'h0);
        chk("abort data_rdata", data_rdata, 32'h0);
        chk("abort inst_rdata", inst_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_drd = '0;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (data_valid || inst_valid) nv++;
        end
        chk("abort valid count", 32'(nv), 32'd0);
        @(posedge clk); #1;

        // Recovery after abort
        start(1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0);
        push(1'b1, 1'b0, 20'h00011, cyc + 3);
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
